if_id_queue: RTL and testbench

Instruction queue between the instruction-fetch stage and the decode stage of the ARM pipeline. It captures each fetched PC/instruction pair from IF, holds up to DEPTH entries, and presents the oldest entry to ID. The queue decouples a decode freeze from fetch: IF is stalled only when the queue is full. A taken branch empties the queue in one cycle.

---
 rtl/if_id_queue_pkg.sv | 20 ++
 rtl/if_id_queue_if.sv | 56 +++++
 rtl/if_id_queue.sv | 131 +++++++++++++
 tb/tb_if_id_queue.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/if_id_queue_pkg.sv
// ----------------------------------------------------------------------------
// ifq_pkg
// Shared definitions for the IF/ID instruction queue.
//   WORD_W        : native PC / instruction width of the ARM pipeline
//   BUBBLE_INSTR  : value presented to decode when the queue holds nothing
//   ifq_entry_t   : one fetched PC/instruction pair
// Optional feature macro used by this slice: IFQ_PERF_EN (performance counters).
// ----------------------------------------------------------------------------
package ifq_pkg;

   localparam int WORD_W = 32;

   localparam logic [WORD_W-1:0] BUBBLE_INSTR = 32'h0000_0000;

   typedef struct packed {
      logic [WORD_W-1:0] pc;
      logic [WORD_W-1:0] instruction;
   } ifq_entry_t;

endpackage : ifq_pkg

// File: rtl/if_id_queue_if.sv
// ----------------------------------------------------------------------------
// if_id_queue_if
// Bundles the fetch-side, decode-side and status signals of the IF/ID queue.
//   master modport : the pipeline around the queue (drives fetch pair,
//                    decode freeze and flush; observes head and status)
//   slave modport  : the queue itself
// Signals:
//   inValid/inPc/inInstruction : pair offered by IF
//   ifFreeze                   : stall request back to IF (queue full)
//   idFreeze                   : decode cannot take the head this cycle
//   flush                      : taken branch, drop everything
//   outValid/outPc/outInstruction : head entry presented to ID
//   count                      : occupancy
// With IFQ_PERF_EN defined, stallCycles, bubbleCycles and flushCount are added.
// ----------------------------------------------------------------------------
interface if_id_queue_if
   import ifq_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int WIDTH = WORD_W
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             inValid;
   logic [WIDTH-1:0] inPc;
   logic [WIDTH-1:0] inInstruction;
   logic             ifFreeze;
   logic             idFreeze;
   logic             flush;
   logic             outValid;
   logic [WIDTH-1:0] outPc;
   logic [WIDTH-1:0] outInstruction;
   logic [CNT_W-1:0] count;
`ifdef IFQ_PERF_EN
   logic [31:0]      stallCycles;
   logic [31:0]      bubbleCycles;
   logic [31:0]      flushCount;
`endif

   modport master (
      output inValid, inPc, inInstruction, idFreeze, flush,
      input  ifFreeze, outValid, outPc, outInstruction, count
`ifdef IFQ_PERF_EN
      , input stallCycles, bubbleCycles, flushCount
`endif
   );

   modport slave (
      input  inValid, inPc, inInstruction, idFreeze, flush,
      output ifFreeze, outValid, outPc, outInstruction, count
`ifdef IFQ_PERF_EN
      , output stallCycles, bubbleCycles, flushCount
`endif
   );

endinterface : if_id_queue_if

// File: rtl/if_id_queue.sv
// ----------------------------------------------------------------------------
// if_id_queue
// Instruction queue between fetch and decode. Captures each fetched
// PC/instruction pair, holds up to DEPTH of them in a circular buffer and
// presents the oldest to decode. Fetch is stalled only when the queue is full;
// a taken branch (flush) empties the queue in one cycle.
// Ports:
//   clk  : pipeline clock, all state changes on the rising edge
//   rst  : synchronous active-high reset (acts like a flush and also clears
//          the performance counters)
//   bus  : if_id_queue_if.slave (fetch pair in, head out, status)
// Optional feature: define IFQ_PERF_EN to add stallCycles, bubbleCycles and
// flushCount (32-bit, wrapping) on the interface.
// ----------------------------------------------------------------------------
module if_id_queue
   import ifq_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int WIDTH = WORD_W
) (
   input  logic         clk,
   input  logic         rst,
   if_id_queue_if.slave bus
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   // Entry storage; contents are deliberately never cleared, only the
   // pointers and occupancy decide what is valid.
   logic [WIDTH-1:0] mem_pc_r    [DEPTH];
   logic [WIDTH-1:0] mem_instr_r [DEPTH];

   logic [PTR_W-1:0] rd_r;
   logic [PTR_W-1:0] wr_r;
   logic [CNT_W-1:0] count_r;

   logic full_s;
   logic empty_s;
   logic push_s;
   logic pop_s;

   // Occupancy status and the accepted push/pop of this cycle.
   // Push is gated by full (not by a same-cycle pop) so that idFreeze has no
   // combinational path to ifFreeze. Flush discards both operations.
   always_comb begin
      full_s  = (count_r == CNT_FULL);
      empty_s = (count_r == CNT_ZERO);
      push_s  = bus.inValid && !full_s && !bus.flush;
      pop_s   = !empty_s && !bus.idFreeze && !bus.flush;
   end

   // Head presentation: the entry at rd, or a bubble when nothing is held.
   always_comb begin
      bus.outValid = !empty_s;
      bus.ifFreeze = full_s;
      bus.count    = count_r;
      if (empty_s) begin
         bus.outPc          = {WIDTH{1'b0}};
         bus.outInstruction = WIDTH'(BUBBLE_INSTR);
      end else begin
         bus.outPc          = mem_pc_r[rd_r];
         bus.outInstruction = mem_instr_r[rd_r];
      end
   end

   // Pointer and occupancy update; reset and flush both empty the queue.
   // Pointers are PTR_W bits wide, so they wrap modulo DEPTH on their own.
   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         rd_r    <= PTR_ZERO;
         wr_r    <= PTR_ZERO;
         count_r <= CNT_ZERO;
      end else begin
         if (push_s) begin
            wr_r <= wr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_r <= rd_r + PTR_ONE;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry write on an accepted push; reset does not touch storage.
   always_ff @(posedge clk) begin
      if (!rst && push_s) begin
         mem_pc_r[wr_r]    <= bus.inPc;
         mem_instr_r[wr_r] <= bus.inInstruction;
      end
   end

`ifdef IFQ_PERF_EN
   logic [31:0] stall_cycles_r;
   logic [31:0] bubble_cycles_r;
   logic [31:0] flush_count_r;

   // Performance counters, free-running and wrapping at 2^32.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles_r  <= 32'd0;
         bubble_cycles_r <= 32'd0;
         flush_count_r   <= 32'd0;
      end else begin
         if (full_s) begin
            stall_cycles_r <= stall_cycles_r + 32'd1;
         end
         if (empty_s && !bus.idFreeze) begin
            bubble_cycles_r <= bubble_cycles_r + 32'd1;
         end
         if (bus.flush) begin
            flush_count_r <= flush_count_r + 32'd1;
         end
      end
   end

   assign bus.stallCycles  = stall_cycles_r;
   assign bus.bubbleCycles = bubble_cycles_r;
   assign bus.flushCount   = flush_count_r;
`endif

endmodule : if_id_queue

// File: tb/tb_if_id_queue.sv
// ----------------------------------------------------------------------------
// tb_if_id_queue
// Self-checking bench for if_id_queue (DEPTH=2, WIDTH=32). A queue of
// ifq_entry_t models the instruction queue; directed scenarios are followed
// by randomized traffic. Works with or without IFQ_PERF_EN.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_if_id_queue;
   import ifq_pkg::*;

   localparam int DEPTH = 2;

   logic clk;
   logic rst;

   if_id_queue_if #(.DEPTH(DEPTH), .WIDTH(WORD_W)) q ();

   if_id_queue #(.DEPTH(DEPTH), .WIDTH(WORD_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (q.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int pass_cnt  = 0;
   int total_cnt = 0;

   // Reference state
   ifq_entry_t  mq[$];
   logic [31:0] m_stall;
   logic [31:0] m_bubble;
   logic [31:0] m_flush;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      if (obs === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Compare every output against the model (called away from the clock edge).
   task automatic check_outputs();
      int sz;
      sz = mq.size();
      check_val("outValid", 32'(q.outValid), 32'(sz != 0));
      check_val("count", 32'(q.count), 32'(sz));
      check_val("ifFreeze", 32'(q.ifFreeze), 32'(sz == DEPTH));
      check_val("outPc", q.outPc, (sz != 0) ? mq[0].pc : 32'h0);
      check_val("outInstruction", q.outInstruction, (sz != 0) ? mq[0].instruction : BUBBLE_INSTR);
`ifdef IFQ_PERF_EN
      check_val("stallCycles", q.stallCycles, m_stall);
      check_val("bubbleCycles", q.bubbleCycles, m_bubble);
      check_val("flushCount", q.flushCount, m_flush);
`endif
   endtask

   // Drive one cycle of inputs, advance the model, clock, then check.
   task automatic cycle(input logic r, input logic v, input logic [31:0] pc,
                        input logic [31:0] ins, input logic idf, input logic fl);
      ifq_entry_t e;
      bit         do_push;
      bit         do_pop;
      int         sz;
      rst             = r;
      q.inValid       = v;
      q.inPc          = pc;
      q.inInstruction = ins;
      q.idFreeze      = idf;
      q.flush         = fl;
      sz = mq.size();
      if (r) begin
         mq.delete();
         m_stall  = 32'd0;
         m_bubble = 32'd0;
         m_flush  = 32'd0;
      end else begin
         m_stall  = m_stall + 32'(sz == DEPTH);
         m_bubble = m_bubble + 32'((sz == 0) && !idf);
         m_flush  = m_flush + 32'(fl);
         if (fl) begin
            mq.delete();
         end else begin
            do_push = v && (sz < DEPTH);
            do_pop  = (sz > 0) && !idf;
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
               e.pc          = pc;
               e.instruction = ins;
               mq.push_back(e);
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
      check_outputs();
   endtask

   initial begin
      logic [31:0] rpc;
      rst             = 1'b1;
      q.inValid       = 1'b0;
      q.inPc          = 32'h0;
      q.inInstruction = 32'h0;
      q.idFreeze      = 1'b0;
      q.flush         = 1'b0;
      m_stall  = 32'd0;
      m_bubble = 32'd0;
      m_flush  = 32'd0;
      @(negedge clk);

      // Reset held with inValid asserted
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b0, 1'b0);
      check_val("rst_count", 32'(q.count), 32'd0);

      // Two pushes with decode free-running
      cycle(1'b0, 1'b1, 32'h0, 32'hE3A0_0001, 1'b0, 1'b0);
      check_val("first_head", q.outInstruction, 32'hE3A0_0001);
      cycle(1'b0, 1'b1, 32'h4, 32'hE3A0_1002, 1'b0, 1'b0);
      check_val("second_head", q.outInstruction, 32'hE3A0_1002);
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

      // Decode frozen: third pair refused while full, then accepted
      cycle(1'b0, 1'b1, 32'h8, 32'hE000_0008, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 32'hC, 32'hE000_000C, 1'b1, 1'b0);
      check_val("full_freeze", 32'(q.ifFreeze), 32'd1);
      cycle(1'b0, 1'b1, 32'h10, 32'hE000_0010, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 32'h10, 32'hE000_0010, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 32'h10, 32'hE000_0010, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

      // Flush while full with a push offered
      cycle(1'b0, 1'b1, 32'h20, 32'hE000_0020, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 32'h24, 32'hE000_0024, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 32'h28, 32'hE000_0028, 1'b0, 1'b1);
      check_val("flush_count", 32'(q.count), 32'd0);

      // Wrap-around streaming
      for (int i = 0; i < 10; i++)
         cycle(1'b0, 1'b1, 32'(i * 4), 32'hE100_0000 | 32'(i), 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

      // Stall cycles and a flush, then reset
      cycle(1'b0, 1'b1, 32'h40, 32'hE000_0040, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 32'h44, 32'hE000_0044, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 32'h48, 32'hE000_0048, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

      // Randomized traffic
      rpc = 32'h1000;
      for (int i = 0; i < 500; i++) begin
         logic r, v, idf, fl;
         r   = ($urandom_range(0, 99) == 0);
         v   = ($urandom_range(0, 3) != 0);
         idf = ($urandom_range(0, 2) == 0);
         fl  = ($urandom_range(0, 19) == 0);
         cycle(r, v, rpc, $urandom, idf, fl);
         rpc = rpc + 32'd4;
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule : tb_if_id_queue
